// File: rtl/spi_master_rx.sv
// ============================================================================
// spi_master_rx
// ----------------------------------------------------------------------------
// Receive half of the SPI master datapath. On every rx_edge strobe the block
// samples sdi1 (single mode) or sdi3..sdi0 (quad mode) and shifts the bits
// MSB-first into a 32-bit word. Each completed word goes to the RX FIFO over
// a valid/ready handshake. The transfer runs for the programmed bit count.
// rx_done flags the final sample. A sticky overflow flag records any word
// that is lost because the output register is still full.
//
// Optional feature (compile-time macro):
//   SPI_MASTER_RX_BSWAP_EN  - byte-reverse each word before it is loaded
//                             into data. Partial words are right-aligned
//                             first and then swapped.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   en             in   sampling enable from the SPI controller FSM
//   rx_edge        in   one-cycle strobe marking an SCK sampling edge
//   rx_done        out  one-cycle pulse after the final sample of a transfer
//   sdi0..sdi3     in   quad data lines (sdi1 is the only line in single mode)
//   en_quad_in     in   1 = quad mode (4 bits per edge), 0 = single mode
//   counter_in     in   transfer length in bits
//   counter_in_upd in   loads counter_in and starts a transfer
//   data           out  assembled word
//   data_valid     out  data holds an unconsumed word
//   data_ready     in   FIFO accepts data this cycle
//   rx_overflow    out  sticky: a word was dropped
//   clr_overflow   in   clears rx_overflow
// ============================================================================
module spi_master_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rx_edge,
    output logic                  rx_done,
    input  logic                  sdi0,
    input  logic                  sdi1,
    input  logic                  sdi2,
    input  logic                  sdi3,
    input  logic                  en_quad_in,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  counter_in_upd,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  rx_overflow,
    input  logic                  clr_overflow
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   running;

    logic [CNT_WIDTH-1:0]   counter_q;
    logic [CNT_WIDTH-1:0]   counter_trgt_q;
    logic [CNT_WIDTH-1:0]   trgt_new;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [DATA_WIDTH-1:0]  shift_nxt;
    logic [DATA_WIDTH-1:0]  word_out;

    logic                   sample;
    logic                   last_sample;
    logic                   word_boundary;
    logic                   word_cmp;

    // In quad mode the controller programs a bit count. Each edge carries
    // four bits, so the edge target is a quarter of that count.
    assign trgt_new = en_quad_in ? (counter_in >> 2) : counter_in;

    // A load strobe outranks any sampling edge in the same cycle. This
    // ensures that a new transfer never starts with a stray bit from the
    // previous one.
    assign sample      = rx_edge && en && running && !counter_in_upd;
    assign last_sample = sample && (counter_q == (counter_trgt_q - CNT_WIDTH'(1)));

    // Single mode shifts one bit per edge. Quad mode shifts a whole nibble.
    // The shift register starts each word at zero, so a short final word
    // comes out right-aligned with no extra handling.
    assign shift_nxt = en_quad_in
                     ? {shift_q[DATA_WIDTH-5:0], sdi3, sdi2, sdi1, sdi0}
                     : {shift_q[DATA_WIDTH-2:0], sdi1};

    // A word closes after 32 single-mode edges or 8 quad-mode edges, or
    // when the transfer ends.
    assign word_boundary = en_quad_in ? (counter_q[2:0] == 3'd7)
                                      : (counter_q[4:0] == 5'd31);
    assign word_cmp      = sample && (last_sample || word_boundary);

`ifdef SPI_MASTER_RX_BSWAP_EN
    // Byte-reverse the completed word on its way to the FIFO.
    assign word_out = {shift_nxt[7:0], shift_nxt[15:8],
                       shift_nxt[23:16], shift_nxt[31:24]};
`else
    assign word_out = shift_nxt;
`endif

    // State register: tracks whether a transfer is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A load starts a transfer only when the new target is
    // nonzero. The last sample returns the block to idle, and later edges
    // are ignored until the next load.
    always_comb begin
        state_d = state_q;
        if (counter_in_upd) begin
            state_d = (trgt_new != '0) ? ST_RUN : ST_IDLE;
        end else if (last_sample) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode of the state machine.
    always_comb begin
        running = 1'b0;
        if (state_q == ST_RUN) begin
            running = 1'b1;
        end
    end

    // Bit counter, target and shift register. A load clears the partial word
    // and restarts counting. The counter wraps to zero on the last sample, so
    // it never exceeds target-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q      <= '0;
            counter_trgt_q <= CNT_WIDTH'(8);
            shift_q        <= '0;
            rx_done        <= 1'b0;
        end else begin
            rx_done <= last_sample;
            if (counter_in_upd) begin
                counter_trgt_q <= trgt_new;
                counter_q      <= '0;
                shift_q        <= '0;
            end else if (sample) begin
                counter_q <= last_sample ? '0 : counter_q + CNT_WIDTH'(1);
                shift_q   <= word_cmp ? '0 : shift_nxt;
            end
        end
    end

    // Output register and overflow flag. A new word is accepted when the
    // register is empty, or when the FIFO takes the old word in the same
    // cycle. While the FIFO stalls, data is held and any new word is
    // dropped, which sets the sticky overflow flag. A set in the same cycle
    // as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= '0;
            data_valid  <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            if (word_cmp) begin
                if (!data_valid || data_ready) begin
                    data       <= word_out;
                    data_valid <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (word_cmp && data_valid && !data_ready) begin
                rx_overflow <= 1'b1;
            end else if (clr_overflow) begin
                rx_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_rx.sv
// ============================================================================
// tb_spi_master_rx
// ----------------------------------------------------------------------------
// Self-checking bench for spi_master_rx. Every transfer is described as a list
// of per-edge line values. A reference model splits that list into the words
// the FIFO should receive: chunks of 32 bits or 8 nibbles, with the last chunk
// right-aligned. A negedge monitor records each handshake and each rx_done
// pulse for comparison.
// ============================================================================
`timescale 1ns/1ps
module tb_spi_master_rx;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rx_edge;
    logic        rx_done;
    logic        sdi0;
    logic        sdi1;
    logic        sdi2;
    logic        sdi3;
    logic        en_quad_in;
    logic [15:0] counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        rx_overflow;
    logic        clr_overflow;

    int          checks;
    int          errors;
    int          edge_vals[$];
    logic [31:0] exp_words[$];
    logic [31:0] got_words[$];
    int          done_count;
    int          done_at;
    int          edges_sent;

    spi_master_rx #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .rx_edge       (rx_edge),
        .rx_done       (rx_done),
        .sdi0          (sdi0),
        .sdi1          (sdi1),
        .sdi2          (sdi2),
        .sdi3          (sdi3),
        .en_quad_in    (en_quad_in),
        .counter_in    (counter_in),
        .counter_in_upd(counter_in_upd),
        .data          (data),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .rx_overflow   (rx_overflow),
        .clr_overflow  (clr_overflow)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so that a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor on the falling edge, halfway between input changes and active
    // edges. A valid/ready pair seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && data_ready) got_words.push_back(data);
            if (rx_done) begin
                done_count = done_count + 1;
                done_at    = edges_sent;
            end
        end
    end

    function automatic logic [31:0] model_swap(input logic [31:0] w);
`ifdef SPI_MASTER_RX_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Reference model: group the first n edge values into words of 32/bpe
    // edges each. The last group may be shorter.
    function automatic void build_expected(input bit quad, input int n);
        int          bpe;
        int          per_word;
        int          k;
        logic [31:0] w;
        bpe      = quad ? 4 : 1;
        per_word = 32 / bpe;
        exp_words.delete();
        w = '0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            w = (w << bpe) | 32'(edge_vals[i]);
            k++;
            if (k == per_word || i == n - 1) begin
                exp_words.push_back(model_swap(w));
                w = '0;
                k = 0;
            end
        end
    endfunction

    function automatic void fill_bits(input logic [31:0] v, input int nbits);
        edge_vals.delete();
        for (int i = nbits - 1; i >= 0; i--) edge_vals.push_back(int'(v[i]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One sampling edge, then a random gap. The gap may contain strobes with
    // en low, which the DUT must ignore.
    task automatic send_edge(input bit quad, input int val);
        rx_edge = 1'b1;
        if (quad) begin
            {sdi3, sdi2, sdi1, sdi0} = 4'(val);
        end else begin
            sdi1 = 1'(val);
            sdi0 = 1'($urandom);
            sdi2 = 1'($urandom);
            sdi3 = 1'($urandom);
        end
        tick();
        rx_edge    = 1'b0;
        edges_sent = edges_sent + 1;
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            if ($urandom_range(0, 3) == 0) begin
                en      = 1'b0;
                rx_edge = 1'b1;
            end
            tick();
            rx_edge = 1'b0;
            en      = 1'b1;
        end
    endtask

    // Load strobe, sometimes with a coincident rx_edge that must lose.
    task automatic start_transfer(input bit quad, input int cin);
        en_quad_in     = quad;
        counter_in     = 16'(cin);
        counter_in_upd = 1'b1;
        rx_edge        = 1'($urandom);
        {sdi3, sdi2, sdi1, sdi0} = 4'($urandom);
        edges_sent     = 0;
        tick();
        counter_in_upd = 1'b0;
        rx_edge        = 1'b0;
    endtask

    task automatic run_and_check(input string name, input bit quad, input int cin,
                                 input int extra);
        int n;
        n = quad ? (cin >> 2) : cin;
        got_words.delete();
        done_count = 0;
        done_at    = -1;
        build_expected(quad, n);
        start_transfer(quad, cin);
        for (int i = 0; i < n; i++) send_edge(quad, edge_vals[i]);
        for (int i = 0; i < extra; i++)
            send_edge(quad, quad ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1)));
        idle(4);

        checks++;
        if (got_words.size() !== exp_words.size()) begin
            errors++;
            $display("[TB] FAIL %s word_count: got %0d expected %0d", name,
                     got_words.size(), exp_words.size());
        end
        for (int i = 0; i < exp_words.size(); i++) begin
            checks++;
            if (i >= got_words.size()) begin
                errors++;
                $display("[TB] FAIL %s word%0d: got none expected %h", name, i, exp_words[i]);
            end else if (got_words[i] !== exp_words[i]) begin
                errors++;
                $display("[TB] FAIL %s word%0d: got %h expected %h", name, i,
                         got_words[i], exp_words[i]);
            end
        end
        checks++;
        if (done_count !== ((n > 0) ? 1 : 0)) begin
            errors++;
            $display("[TB] FAIL %s done_count: got %0d expected %0d", name, done_count,
                     (n > 0) ? 1 : 0);
        end
        if (n > 0) begin
            checks++;
            if (done_at !== n) begin
                errors++;
                $display("[TB] FAIL %s done_edge: got %0d expected %0d", name, done_at, n);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks += 4;
        if (data !== 32'h0)      begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", data); end
        if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", data_valid); end
        if (rx_done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", rx_done); end
        if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", rx_overflow); end
        // Edges with no transfer loaded must be ignored.
        got_words.delete();
        done_count = 0;
        for (int i = 0; i < 40; i++) send_edge(0, 1);
        idle(3);
        checks++;
        if (got_words.size() !== 0 || done_count !== 0 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_edges: got words=%0d done=%0d expected 0 0",
                     got_words.size(), done_count);
        end
    endtask

    task automatic test_single_word();
        fill_bits(32'hA5C3_0F96, 32);
        run_and_check("single32", 0, 32, 3);
    endtask

    task automatic test_quad_two_words();
        edge_vals.delete();
        for (int i = 1; i <= 16; i++) edge_vals.push_back(i % 16);
        run_and_check("quad64", 1, 64, 3);
    endtask

    task automatic test_partial_word();
        fill_bits(32'h0000_0ABC, 12);
        run_and_check("single12", 0, 12, 5);
    endtask

    task automatic test_overflow();
        logic [31:0] first;
        data_ready = 1'b0;
        got_words.delete();
        edge_vals.delete();
        for (int i = 1; i <= 16; i++) edge_vals.push_back(i % 16);
        build_expected(1, 16);
        first = exp_words[0];
        start_transfer(1, 64);
        for (int i = 0; i < 16; i++) send_edge(1, edge_vals[i]);
        idle(2);
        checks += 4;
        if (data_valid !== 1'b1)  begin errors++; $display("[TB] FAIL ovf_valid: got %b expected 1", data_valid); end
        if (data !== first)       begin errors++; $display("[TB] FAIL ovf_hold: got %h expected %h", data, first); end
        if (rx_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", rx_overflow); end
        if (got_words.size() !== 0) begin errors++; $display("[TB] FAIL ovf_no_hs: got %0d expected 0", got_words.size()); end

        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", rx_overflow); end

        // Set and clear in the same cycle: the set wins.
        start_transfer(1, 4);
        rx_edge      = 1'b1;
        clr_overflow = 1'b1;
        {sdi3, sdi2, sdi1, sdi0} = 4'h9;
        tick();
        rx_edge      = 1'b0;
        clr_overflow = 1'b0;
        tick();
        checks += 2;
        if (rx_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", rx_overflow); end
        if (data !== first)       begin errors++; $display("[TB] FAIL ovf_hold2: got %h expected %h", data, first); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;

        data_ready = 1'b1;
        idle(4);
        checks += 3;
        if (got_words.size() !== 1) begin
            errors++;
            $display("[TB] FAIL ovf_release_count: got %0d expected 1", got_words.size());
        end else if (got_words[0] !== first) begin
            errors++;
            $display("[TB] FAIL ovf_release_data: got %h expected %h", got_words[0], first);
        end
        if (data_valid !== 1'b0)  begin errors++; $display("[TB] FAIL ovf_drained: got %b expected 0", data_valid); end
        if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %b expected 0", rx_overflow); end
    endtask

    task automatic test_reset_mid_transfer();
        start_transfer(0, 32);
        for (int i = 0; i < 9; i++) send_edge(0, int'($urandom_range(0, 1)));
        rst     = 1'b1;
        rx_edge = 1'b1;
        sdi1    = 1'b1;
        tick();
        rst     = 1'b0;
        rx_edge = 1'b0;
        checks += 3;
        if (data !== 32'h0)      begin errors++; $display("[TB] FAIL midrst_data: got %h expected 0", data); end
        if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", data_valid); end
        if (rx_done !== 1'b0)    begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", rx_done); end
        fill_bits(32'h0000_005A, 8);
        run_and_check("after_reset", 0, 8, 2);
    endtask

    task automatic test_random();
        for (int t = 0; t < 15; t++) begin
            bit quad;
            int cin;
            int n;
            quad = 1'($urandom);
            cin  = quad ? int'($urandom_range(0, 160)) : int'($urandom_range(0, 90));
            n    = quad ? (cin >> 2) : cin;
            edge_vals.delete();
            for (int i = 0; i < n; i++)
                edge_vals.push_back(quad ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1)));
            run_and_check($sformatf("rand%0d", t), quad, cin, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        done_count     = 0;
        done_at        = -1;
        edges_sent     = 0;
        rst            = 1'b1;
        en             = 1'b1;
        rx_edge        = 1'b0;
        sdi0           = 1'b0;
        sdi1           = 1'b0;
        sdi2           = 1'b0;
        sdi3           = 1'b0;
        en_quad_in     = 1'b0;
        counter_in     = 16'h0;
        counter_in_upd = 1'b0;
        data_ready     = 1'b1;
        clr_overflow   = 1'b0;

        test_reset();
        test_single_word();
        test_quad_two_words();
        test_partial_word();
        test_overflow();
        test_reset_mid_transfer();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
